// File: rtl/rtc_pkg.sv
// Shared types for the RTC multiplexed-bus controller: FSM encoding, strobe levels, bus bundle.
package rtc_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADR_SET = 3'd1,
        ST_ADR_STB = 3'd2,
        ST_ADR_HLD = 3'd3,
        ST_DAT_SET = 3'd4,
        ST_DAT_STB = 3'd5,
        ST_DAT_HLD = 3'd6,
        ST_RECOVER = 3'd7
    } rtc_state_e;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;
    localparam logic AD_ADDR = 1'b0;
    localparam logic AD_DATA = 1'b1;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       a_d;
        logic       ad_oe;
        logic [7:0] ad_out;
    } rtc_bus_t;

    function automatic logic is_adr_phase(input rtc_state_e s);
        return s inside {ST_ADR_SET, ST_ADR_STB, ST_ADR_HLD};
    endfunction

    function automatic logic is_dat_phase(input rtc_state_e s);
        return s inside {ST_DAT_SET, ST_DAT_STB, ST_DAT_HLD};
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Host request / RTC AD-bus signal bundle. slave = controller side, master = host + pad side.
interface rtc_bus_ctrl_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, busy, done
    );

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, busy, done
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: loads on state entry, decrements to zero and sticks there.
// Latency: expired_o is registered, high in the last cycle of a loaded phase.
// Backpressure: none; load_i always wins over counting.
module rtc_phase_timer
    import rtc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed AD-bus controller: one host request -> address phase + data phase with strobes.
// Latency: done in cycle 6*PHASE_CYC after start is sampled; optional RECOVER_CYC idle tail (RTC_BUS_RECOVER_EN).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int PHASE_CYC   = 4,
    parameter int RECOVER_CYC = 8
) (
    input logic           clk,
    input logic           rst_n,
    rtc_bus_ctrl_if.slave bus
);

    if (PHASE_CYC < 1 || PHASE_CYC > 255 || RECOVER_CYC < 1 || RECOVER_CYC > 255) begin : g_param_chk
        $error("rtc_bus_ctrl: PHASE_CYC and RECOVER_CYC must be in 1..255");
    end

    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYC - 1);
`ifdef RTC_BUS_RECOVER_EN
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYC - 1);
`endif

    rtc_state_e       state_q, state_d;
    logic             rw_q, rw_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    rtc_bus_t         pins_q, pins_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_expired;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .cnt_o      (tmr_cnt),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ADR_SET;
                    rw_d     = bus.rw;
                    addr_d   = bus.addr;
                    wdata_d  = bus.wdata;
                    tmr_load = 1'b1;
                    tmr_val  = PHASE_LOAD;
                end
            end
            ST_ADR_SET, ST_ADR_STB, ST_ADR_HLD, ST_DAT_SET, ST_DAT_STB: begin
                if (tmr_expired) begin
                    state_d  = rtc_state_e'(state_q + 3'd1);
                    tmr_load = 1'b1;
                    tmr_val  = PHASE_LOAD;
                end
            end
            ST_DAT_HLD: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
`ifdef RTC_BUS_RECOVER_EN
                    state_d  = ST_RECOVER;
                    tmr_val  = RECOVER_LOAD;
`else
                    state_d  = ST_IDLE;
`endif
                end
            end
            ST_RECOVER: begin
`ifdef RTC_BUS_RECOVER_EN
                if (tmr_expired) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are fed from the next state so pins change exactly on state boundaries.
    always_comb begin
        pins_d = '{cs_n: STB_OFF, rd_n: STB_OFF, wr_n: STB_OFF,
                   a_d: AD_ADDR, ad_oe: 1'b0, ad_out: 8'h00};
        if (is_adr_phase(state_d)) begin
            pins_d.cs_n   = STB_ON;
            pins_d.ad_oe  = 1'b1;
            pins_d.ad_out = addr_d;
            if (state_d == ST_ADR_STB) begin
                pins_d.wr_n = STB_ON;
            end
        end else if (is_dat_phase(state_d)) begin
            pins_d.cs_n = STB_ON;
            pins_d.a_d  = AD_DATA;
            if (rw_d) begin
                if (state_d == ST_DAT_STB) begin
                    pins_d.rd_n = STB_ON;
                end
            end else begin
                pins_d.ad_oe  = 1'b1;
                pins_d.ad_out = wdata_d;
                if (state_d == ST_DAT_STB) begin
                    pins_d.wr_n = STB_ON;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DAT_HLD) &&
                 (tmr_load ? (tmr_val == '0) : (tmr_cnt == CNT_W'(1)));

        rdata_d = rdata_q;
        if (state_q == ST_DAT_STB && tmr_expired && rw_q) begin
            rdata_d = bus.ad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            pins_q  <= '{cs_n: STB_OFF, rd_n: STB_OFF, wr_n: STB_OFF,
                         a_d: AD_ADDR, ad_oe: 1'b0, ad_out: 8'h00};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            pins_q  <= pins_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.cs_n   = pins_q.cs_n;
    assign bus.rd_n   = pins_q.rd_n;
    assign bus.wr_n   = pins_q.wr_n;
    assign bus.a_d    = pins_q.a_d;
    assign bus.ad_oe  = pins_q.ad_oe;
    assign bus.ad_out = pins_q.ad_out;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: directed spec scenarios followed by randomized traffic and resets.
module tb_rtc_bus_ctrl;
    localparam int P    = 4;
    localparam int RC   = 8;
`ifdef RTC_BUS_RECOVER_EN
    localparam int R    = RC;
`else
    localparam int R    = 0;
`endif
    localparam int TLEN = 6 * P;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl #(.PHASE_CYC(P), .RECOVER_CYC(RC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         s;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rv;
    } txn_t;

    txn_t       q[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         rec_end = -1;
    int         free_cyc = 0;
    int         dones = 0;
    logic [7:0] last_rdata = 8'h00;
    bit         chk_en = 1'b0;
    bit         just_reset = 1'b0;
    bit         pending_flush = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of host inputs and update the reference model's view of acceptance.
    task automatic step(input bit st, input bit r, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] rv, input bit rst_lo);
        int n;
        @(posedge clk);
        #1;
        n = cyc;
        just_reset = pending_flush;
        if (pending_flush) begin
            q.delete();
            last_rdata    = 8'h00;
            rec_end       = -1;
            pending_flush = 1'b0;
        end
        rst_n     = !rst_lo;
        bus.start = st;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = w;
        if (rst_lo) begin
            pending_flush = 1'b1;
            free_cyc      = n + 1;
        end else if (st && n >= free_cyc) begin
            q.push_back('{n, r, a, w, rv});
            free_cyc = n + TLEN + 1 + R;
        end
        if (q.size() > 0 && q[0].rw && (n - q[0].s) == 5 * P)
            bus.ad_in = q[0].rv;
        else
            bus.ad_in = 8'($urandom);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    endtask

    // Monitor: expected pin levels come from the transaction's position in its 6-phase frame.
    always @(negedge clk) begin
        int         n, k, ph;
        logic [6:0] e, m, a;
        logic [7:0] e_adout, e_rdata;
        if (chk_en) begin
            n = cyc;
            if (q.size() > 0 && (n - q[0].s) > TLEN) begin
                tests++;
                fails++;
                $display("FAIL done_missing cyc=%0d actual=no_done required=done_at_%0d", n, q[0].s + TLEN);
                q.pop_front();
            end
            e       = 7'b0011100;
            m       = 7'b1111101;
            e_adout = 8'h00;
            e_rdata = last_rdata;
            if (q.size() > 0 && n > q[0].s) begin
                k    = n - q[0].s;
                ph   = (k - 1) / P;
                e[6] = 1'b1;
                e[5] = (k == TLEN);
                e[4] = 1'b0;
                e[3] = !(ph == 4 && q[0].rw);
                e[2] = !(ph == 1 || (ph == 4 && !q[0].rw));
                e[1] = (ph >= 3);
                e[0] = (ph < 3) || !q[0].rw;
                m[1] = 1'b1;
                e_adout = (ph < 3) ? q[0].addr : q[0].wdata;
                if (q[0].rw && k > 5 * P) e_rdata = q[0].rv;
            end else if (n <= rec_end) begin
                e[6] = 1'b1;
            end
            if (just_reset) m[1] = 1'b1;
            a = {bus.busy, bus.done, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe};
            check("pins{busy,done,cs_n,rd_n,wr_n,a_d,ad_oe}", 32'(a & m), 32'(e & m));
            if (e[0]) check("ad_out", bus.ad_out, e_adout);
            if (just_reset) check("ad_out_after_reset", bus.ad_out, 8'h00);
            check("rdata", bus.rdata, e_rdata);
            tests++;
            if ((!bus.rd_n && !bus.wr_n) || (bus.ad_oe && !bus.rd_n)) begin
                fails++;
                $display("FAIL strobe_conflict cyc=%0d actual rd_n=%b wr_n=%b ad_oe=%b required no overlap",
                         n, bus.rd_n, bus.wr_n, bus.ad_oe);
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done cyc=%0d actual=1 required=0", n);
                end else begin
                    check("done_latency", 32'(n - q[0].s), 32'(TLEN));
                    if (q[0].rw) last_rdata = q[0].rv;
                    rec_end = n + R;
                    q.pop_front();
                    dones++;
                end
            end
        end
    end

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;
        bus.ad_in = 8'h00;
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk_en = 1'b1;
        idle(2);

        step(1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 1'b0);
        idle(TLEN + R + 2);

        step(1'b1, 1'b1, 8'h22, 8'h00, 8'h37, 1'b0);
        idle(TLEN + R + 2);
        check("rdata_after_read", bus.rdata, 8'h37);

        step(1'b1, 1'b0, 8'h30, 8'hA5, 8'h00, 1'b0);
        idle(TLEN + R + 2);
        check("rdata_held_over_write", bus.rdata, 8'h37);

        d0 = dones;
        step(1'b1, 1'b1, 8'h40, 8'h00, 8'hC3, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 8'h41, 8'h11, 8'h00, 1'b0);
        idle(TLEN + R + 2);
        check("single_done_with_stray_start", 32'(dones - d0), 32'd1);

        d0 = dones;
        step(1'b1, 1'b1, 8'h22, 8'h00, 8'h5A, 1'b0);
        idle(4 * P + 1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        check("reset_strobes", {bus.cs_n, bus.rd_n, bus.wr_n}, 3'b111);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_rdata", bus.rdata, 8'h00);
        idle(TLEN + R + 2);
        check("no_done_after_abort", 32'(dones - d0), 32'd0);

        repeat (2 * (TLEN + 1 + R) + 2)
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        idle(TLEN + R + 2);

        repeat (1500)
            step($urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), $urandom_range(0, 399) == 0);

        for (int i = 0; i < 400 && q.size() > 0; i++) idle(1);
        tests++;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
        idle(R + 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 4, clk cycles per bus phase (legal 1..255).
REQ-002 SHALL have parameter RECOVER_CYC, default 8, idle cycles after each transaction when RTC_BUS_RECOVER_EN is defined (legal 1..255).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  transaction request, sampled only in IDLE.
REQ-006 rw  in  1  1=read, 0=write; captured with start.
REQ-007 addr  in  8  RTC register address; captured with start.
REQ-008 wdata  in  8  write data; captured with start.
REQ-009 ad_in  in  8  RTC multiplexed AD bus, input side.
REQ-010 ad_out  out  8  RTC AD bus, output side.
REQ-011 ad_oe  out  1  1=drive ad_out onto bus (tristate at top level).
REQ-012 cs_n, rd_n, wr_n, a_d  out  1 each  RTC strobes; a_d 0=address phase, 1=data phase.
REQ-013 rdata  out  8  read data, feeds downstream 8-bit data register.
REQ-014 busy  out  1  high from accepted start until return to IDLE.
REQ-015 done  out  1  one-cycle pulse at transaction end.

Function
REQ-016 FSM states SHALL be IDLE, ADR_SET, ADR_STB, ADR_HLD, DAT_SET, DAT_STB, DAT_HLD, RECOVER, each non-IDLE state lasting exactly PHASE_CYC cycles (RECOVER: RECOVER_CYC).
REQ-017 IDLE with start=1 SHALL latch rw/addr/wdata and enter ADR_SET next cycle; start outside IDLE SHALL be ignored (no queueing).
REQ-018 ADR_SET/ADR_STB/ADR_HLD SHALL drive a_d=0, cs_n=0, ad_oe=1, ad_out=addr; wr_n=0 only in ADR_STB; rd_n=1.
REQ-019 DAT_* states SHALL drive a_d=1, cs_n=0; write: ad_oe=1, ad_out=wdata, wr_n=0 only in DAT_STB; read: ad_oe=0, rd_n=0 only in DAT_STB.
REQ-020 Read SHALL capture ad_in into rdata on the last DAT_STB cycle; rdata SHALL hold otherwise, including across writes.
REQ-021 done SHALL assert during the last DAT_HLD cycle; busy SHALL deassert the cycle the FSM re-enters IDLE.
REQ-022 Without RECOVER, start-to-done latency SHALL be 6*PHASE_CYC cycles; back-to-back start accepted the cycle after done.
REQ-023 rd_n and wr_n SHALL never be low simultaneously; ad_oe SHALL never be 1 while rd_n=0.
REQ-024 Phase counter SHALL be 8 bits, reload to PHASE_CYC-1 on state entry, decrement to 0; no wrap.
REQ-025 Outputs SHALL be registered (glitch-free strobes).

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE, cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0, rdata=0, busy=0, done=0, counter=0.
REQ-027 Reset mid-transaction SHALL abort it immediately with no done pulse; start during reset ignored.

Configuration
REQ-028 With RTC_BUS_RECOVER_EN defined, DAT_HLD SHALL go to RECOVER (all strobes inactive, ad_oe=0, busy=1) then IDLE; latency to done unchanged, next start accepted RECOVER_CYC cycles later.
REQ-029 Without RTC_BUS_RECOVER_EN, DAT_HLD SHALL go directly to IDLE and RECOVER logic SHALL not exist.

Structure
REQ-030 Shared package rtc_pkg SHALL hold the FSM state encoding and strobe-level constants (active-low values, a_d address/data codes).
REQ-031 Phase timer SHALL be sub-module rtc_phase_timer (load, count, expired flag); rest is a single FSM.

Verification
REQ-032 PHASE_CYC=4, write addr=0x21 wdata=0x59 -> wr_n low cycles 5-8 with ad_out=0x21 a_d=0, cycles 17-20 with ad_out=0x59 a_d=1; done at cycle 24.
REQ-033 Read addr=0x22, ad_in=0x37 during DAT_STB -> ad_oe=0, rd_n low 4 cycles, rdata=0x37 after done, held through following write.
REQ-034 start pulsed at cycle 10 of an active transaction -> ignored; exactly one done.
REQ-035 rst_n low in DAT_STB of a read -> next cycle all strobes 1, busy=0, no done, rdata=0.
REQ-036 Back-to-back reads, start held high -> second ADR_SET begins cycle after IDLE re-entry; with RTC_BUS_RECOVER_EN, RECOVER_CYC=8 inactive cycles between transactions.
REQ-037 Assertion over all tests: never rd_n=0 with wr_n=0, never ad_oe=1 with rd_n=0.
